// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache<->memory request interface:
// FSM state encoding, word geometry and read/write opcode constants.
package mem_if_pkg;

    localparam int   MEM_WORD_W   = 32;
    localparam int   MEM_ADDR_LSB = 2;
    localparam logic MEM_WR       = 1'b1;
    localparam logic MEM_RD       = 1'b0;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_RESP,
        MEM_DONE
    } mem_state_e;

endpackage

// File: rtl/mem_word_ram.sv
// Single-port 2**ADDR_W x 32 synchronous RAM with registered read.
// rclr zeroes the read register (reset, or a suppressed out-of-range read).
import mem_if_pkg::*;

module mem_word_ram #(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic                  rclr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [MEM_WORD_W-1:0] wdata,
    output logic [MEM_WORD_W-1:0] rdata
);

    logic [MEM_WORD_W-1:0] mem_q [2**ADDR_W];
    logic [MEM_WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (rclr) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_req_responder.sv
// Memory-side responder: one word read/write per handshake, one-cycle ready
// pulse LATENCY cycles after capture. MEM_ADDR_CHECK_EN adds the mem_req_err port.
import mem_if_pkg::*;

module mem_req_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_req_addr,
    input  logic                  mem_req_valid,
    input  logic                  mem_req_wr,
    input  logic [MEM_WORD_W-1:0] mem_wr_data,
    output logic [MEM_WORD_W-1:0] mem_req_data,
    output logic                  mem_req_ready
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic                  mem_req_err
`endif
);

    mem_state_e            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic                  oor_q, oor_d;
    logic                  wr_q, wr_d;
    logic [MEM_WORD_W-1:0] wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;

    logic                  in_oor;
    logic [ADDR_W-1:0]     cur_idx;
    logic                  cur_oor;
    logic                  cur_wr;
    logic                  ram_we, ram_re, ram_rclr;

`ifdef MEM_ADDR_CHECK_EN
    assign in_oor = |mem_req_addr[31:ADDR_W+MEM_ADDR_LSB];
    logic addr_unused;
    assign addr_unused = ^mem_req_addr[MEM_ADDR_LSB-1:0];
`else
    assign in_oor = 1'b0;
    logic addr_unused;
    assign addr_unused = ^{mem_req_addr[31:ADDR_W+MEM_ADDR_LSB], mem_req_addr[MEM_ADDR_LSB-1:0], err_q};
`endif

    // In IDLE the request is still on the inputs; afterwards the captured copy rules.
    assign cur_idx = (state_q == MEM_IDLE) ? mem_req_addr[ADDR_W+MEM_ADDR_LSB-1:MEM_ADDR_LSB] : idx_q;
    assign cur_oor = (state_q == MEM_IDLE) ? in_oor     : oor_q;
    assign cur_wr  = (state_q == MEM_IDLE) ? mem_req_wr : wr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        oor_d   = oor_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            MEM_IDLE: begin
                if (mem_req_valid) begin
                    idx_d   = cur_idx;
                    oor_d   = in_oor;
                    wr_d    = mem_req_wr;
                    wdata_d = mem_wr_data;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? MEM_RESP : MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = MEM_RESP;
            end
            MEM_RESP: state_d = MEM_DONE;
            // Wait out the requester's stale valid before accepting again.
            MEM_DONE: if (!mem_req_valid) state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase

        ready_d = (state_d == MEM_RESP);
        err_d   = ready_d & cur_oor;

        // Read is launched the cycle before RESP so the RAM register holds it in RESP.
        ram_re   = ready_d && (cur_wr == MEM_RD);
        ram_rclr = rst || (ram_re && cur_oor);
        ram_we   = (state_q == MEM_RESP) && (wr_q == MEM_WR) && !oor_q && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    mem_word_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .rclr  (ram_rclr),
        .addr  (cur_idx),
        .wdata (wdata_q),
        .rdata (mem_req_data)
    );

    assign mem_req_ready = ready_q;
`ifdef MEM_ADDR_CHECK_EN
    assign mem_req_err = err_q;
`endif

endmodule

// File: tb/tb_mem_req_responder.sv
// Directed bench for mem_req_responder: instance 0 with LATENCY=4, instance 1
// with LATENCY=1. Inputs driven and outputs sampled on the falling edge.
module tb_mem_req_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr [2];
    logic        vld  [2];
    logic        wr   [2];
    logic [31:0] wd   [2];
    logic [31:0] rdat [2];
    logic        rdy  [2];
    logic        er_s [2];

    int checks   = 0;
    int failures = 0;

`ifdef MEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_req_responder #(.ADDR_W(10), .LATENCY(4)) dut0 (
        .clk(clk), .rst(rst), .mem_req_addr(addr[0]), .mem_req_valid(vld[0]),
        .mem_req_wr(wr[0]), .mem_wr_data(wd[0]), .mem_req_data(rdat[0]),
        .mem_req_ready(rdy[0])
`ifdef MEM_ADDR_CHECK_EN
        , .mem_req_err(er_s[0])
`endif
    );

    mem_req_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_req_addr(addr[1]), .mem_req_valid(vld[1]),
        .mem_req_wr(wr[1]), .mem_wr_data(wd[1]), .mem_req_data(rdat[1]),
        .mem_req_ready(rdy[1])
`ifdef MEM_ADDR_CHECK_EN
        , .mem_req_err(er_s[1])
`endif
    );

`ifndef MEM_ADDR_CHECK_EN
    assign er_s[0] = 1'b0;
    assign er_s[1] = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full handshake from a falling edge: returns cycles to ready, data and err in
    // the ready cycle. Valid is held 'hold' extra cycles after ready (stale valid).
    task automatic req(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int hold, output int lat, output logic [31:0] rd, output logic e);
        lat = 0; rd = '0; e = 1'b0;
        vld[s] = 1'b1; wr[s] = w; addr[s] = a; wd[s] = d;
        for (int i = 1; i <= 300 && lat == 0; i++) begin
            @(negedge clk);
            if (rdy[s]) begin
                lat = i; rd = rdat[s]; e = er_s[s];
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("stale_valid_no_pulse", {31'b0, rdy[s]}, 32'd0);
        end
        vld[s] = 1'b0;
        @(negedge clk);
        chk("pulse_one_cycle", {31'b0, rdy[s]}, 32'd0);
        @(negedge clk);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        e;

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            vld[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wd[s] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1. Reset then idle
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_ready0", {31'b0, rdy[0]}, 32'd0);
            chk("idle_data0", rdat[0], 32'd0);
            chk("idle_err0", {31'b0, er_s[0]}, 32'd0);
        end
        chk("idle_ready1", {31'b0, rdy[1]}, 32'd0);
        chk("idle_data1", rdat[1], 32'd0);

        // 2. Write then read at LATENCY=4
        req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, lat, rd, e);
        chk("wr_latency", lat, 4);
        chk("wr_data_unchanged", rd, 32'd0);
        chk("wr_err", {31'b0, e}, 32'd0);
        req(0, 1'b0, 32'h0000_0010, 32'h0, 0, lat, rd, e);
        chk("rd_latency", lat, 4);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_data_held", rdat[0], 32'hDEAD_BEEF);
        req(0, 1'b0, 32'h0000_0013, 32'h0, 0, lat, rd, e);
        chk("rd_byte_offset_ignored", rd, 32'hDEAD_BEEF);

        // 3. Stale valid after ready
        req(0, 1'b0, 32'h0000_0010, 32'h0, 3, lat, rd, e);
        chk("stale_rd_latency", lat, 4);
        req(0, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, 6, lat, rd, e);
        chk("after_stale_latency", lat, 4);
        req(0, 1'b0, 32'h0000_0014, 32'h0, 0, lat, rd, e);
        chk("raw_data", rd, 32'hCAFE_F00D);
        req(0, 1'b1, 32'h0000_0018, 32'h0000_0001, 0, lat, rd, e);
        chk("data_held_over_write", rd, 32'hCAFE_F00D);

        // 4. Reset mid-operation
        req(0, 1'b1, 32'h0000_0020, 32'h1111_2222, 0, lat, rd, e);
        vld[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'h55AA_55AA;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_early_pulse", {31'b0, rdy[0]}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_pulse", {31'b0, rdy[0]}, 32'd0);
        chk("abort_data_reset", rdat[0], 32'd0);
        rst = 1'b0; vld[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_still_idle", {31'b0, rdy[0]}, 32'd0);
        req(0, 1'b0, 32'h0000_0020, 32'h0, 0, lat, rd, e);
        chk("abort_old_value", rd, 32'h1111_2222);

        // Reset landing on the edge that closes RESP: write must not commit
        vld[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'h7777_8888;
        repeat (4) @(negedge clk);
        chk("resp_rst_pulse_seen", {31'b0, rdy[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; vld[0] = 1'b0;
        chk("resp_rst_ready_low", {31'b0, rdy[0]}, 32'd0);
        repeat (2) @(negedge clk);
        req(0, 1'b0, 32'h0000_0020, 32'h0, 0, lat, rd, e);
        chk("resp_rst_not_committed", rd, 32'h1111_2222);

        // 5. LATENCY=1
        req(1, 1'b1, 32'h0000_0004, 32'h1234_5678, 0, lat, rd, e);
        chk("lat1_wr_latency", lat, 1);
        req(1, 1'b0, 32'h0000_0004, 32'h0, 0, lat, rd, e);
        chk("lat1_rd_latency", lat, 1);
        chk("lat1_rd_data", rd, 32'h1234_5678);

        // 6. Upper address bits: error with the check, aliasing without
        req(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 0, lat, rd, e);
        req(0, 1'b1, 32'h0001_0000, 32'hA5A5_A5A5, 0, lat, rd, e);
        chk("oor_wr_latency", lat, 4);
        chk("oor_wr_err", {31'b0, e}, {31'b0, CHK});
        req(0, 1'b0, 32'h0001_0000, 32'h0, 0, lat, rd, e);
        chk("oor_rd_latency", lat, 4);
        chk("oor_rd_err", {31'b0, e}, {31'b0, CHK});
        chk("oor_rd_data", rd, CHK ? 32'h0 : 32'hA5A5_A5A5);
        chk("err_cleared", {31'b0, er_s[0]}, 32'd0);
        req(0, 1'b0, 32'h0000_0000, 32'h0, 0, lat, rd, e);
        chk("ram0_data", rd, CHK ? 32'h0BAD_F00D : 32'hA5A5_A5A5);
        chk("ram0_err", {31'b0, e}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
